sysmgr_seq: RTL and testbench
=============================

SYSMGR_SEQ -- requirements
Module: sysmgr_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 3: number of reset/sync domains, legal range 1..8.
REQ-002 SHALL have parameter LOCK_FILT, default 64: consecutive pll_lock-high samples required before release, legal range 2..1024.
REQ-003 SHALL have parameter STAGGER, default 16: cycles between successive domain releases, legal range 1..256.
REQ-004 SHALL have parameter DIV, default 4: sync strobe period in cycles, power of two, legal range 2..16; PW = log2(DIV).
REQ-005 SHALL have parameter DW, default 4: PLL dynamic delay width.
REQ-006 SHALL have parameter DLY_INIT, default 0: delay value after reset.
REQ-007 SHALL have port clk, input, 1 bit: sole clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port pll_lock, input, 1 bit: raw PLL lock, already synchronous to clk.
REQ-010 SHALL have port sync_phase, input, N_DOM*PW bits: per-domain strobe phase; field i occupies bits [i*PW +: PW].
REQ-011 SHALL have port dly_valid, input, 1 bit: delay change request.
REQ-012 SHALL have port dly_data, input, DW bits: requested delay.
REQ-013 SHALL have port dly_ready, output, 1 bit: request accepted when dly_valid and dly_ready are both high.
REQ-014 SHALL have port delay, output, DW bits: registered delay value driven to the PLL.
REQ-015 SHALL have port dom_rst, output, N_DOM bits: per-domain reset, active-high, registered.
REQ-016 SHALL have port sync, output, N_DOM bits: per-domain single-cycle sync strobe, registered.
REQ-017 SHALL have port ready, output, 1 bit: high only in state RUN.

Function
REQ-018 SHALL implement an FSM with states WAIT_LOCK, FILTER, RELEASE, RUN and SETTLE.
REQ-019 In WAIT_LOCK, a sampled pll_lock=1 SHALL move the FSM to FILTER with the filter count set to 1.
REQ-020 In FILTER, each pll_lock=1 sample SHALL increment the filter count; any pll_lock=0 sample SHALL return the FSM to WAIT_LOCK with the count cleared.
REQ-021 On the edge at which the LOCK_FILT-th consecutive high sample is seen, the FSM SHALL enter RELEASE, dom_rst[0] SHALL go low, and the sync phase counter SHALL be set to 0.
REQ-022 In RELEASE, dom_rst[i] SHALL go low exactly STAGGER*i cycles after dom_rst[0]; on the edge at which dom_rst[N_DOM-1] goes low the FSM SHALL enter RUN (N_DOM=1: RUN directly).
REQ-023 The phase counter SHALL run modulo DIV from the RELEASE entry.
REQ-024 sync[i] SHALL be high for exactly one cycle when phase counter == sync_phase field i and dom_rst[i]==0, and SHALL be low otherwise.
REQ-025 dly_ready SHALL equal (state==RUN && pll_lock), combinationally.
REQ-026 On an accepted delay request: delay <= dly_data on the same edge, all dom_rst <= 1, sync <= 0, and the FSM SHALL enter SETTLE.
REQ-027 SETTLE SHALL wait LOCK_FILT cycles, then proceed exactly as FILTER on the following lock samples; a pll_lock=0 sample during SETTLE SHALL behave as lock loss.
REQ-028 Lock loss (pll_lock=0 sampled in RELEASE, RUN or SETTLE) SHALL, on the next edge, set all dom_rst to 1 and sync to 0, enter WAIT_LOCK, and leave delay unchanged.
REQ-029 If lock loss and dly_valid occur in the same cycle, lock loss SHALL win and the request SHALL NOT be accepted (dly_ready is low that cycle).
REQ-030 An unaccepted dly_valid SHALL have no effect; dly_data SHALL be sampled only on acceptance.
REQ-031 Counters SHALL saturate or clear and SHALL never wrap into an early release.

Reset
REQ-032 While rst_n=0 at a clock edge: state=WAIT_LOCK, dom_rst=all 1, sync=0, delay=DLY_INIT, ready=0, all counters=0.
REQ-033 rst_n asserted mid-sequence SHALL abort it with the values of REQ-032 on that edge.

Structure
REQ-034 Package sysmgr_pkg SHALL hold the FSM state enum and the counter-width helper function (clog2-based widths for LOCK_FILT, STAGGER*(N_DOM-1) and DIV).
REQ-035 The consecutive-sample lock filter SHALL be a sub-module, sysmgr_lock_filt (clk, rst_n, pll_lock, restart, locked); everything else stays in sysmgr_seq.

Verification (defaults unless stated)
REQ-036 Lock rises at cycle 10 and stays high -> dom_rst[0] falls at cycle 73, dom_rst[1] at 89, dom_rst[2] at 105, ready=1 from 105.
REQ-037 Lock low for 1 cycle at filter count 40 -> count restarts; release is delayed by exactly the elapsed cycles.
REQ-038 sync_phase={2,1,0} in RUN -> sync[0] at phase 0, sync[1] at phase 1, sync[2] at phase 2, each with period 4.
REQ-039 In RUN, dly_valid with dly_data=9 -> delay=9 on the next edge, dom_rst=3'b111, SETTLE 64 cycles, re-filter, staggered release again.
REQ-040 dly_valid and lock drop in the same cycle -> delay unchanged, WAIT_LOCK entered, dom_rst=3'b111.
REQ-041 rst_n=0 during RELEASE after dom_rst[0] has released -> dom_rst=3'b111, delay=DLY_INIT, sync=0 on that edge.

Source files
------------

// File: rtl/sysmgr_pkg.sv
// Shared types and width helpers for the system manager sequencer.
package sysmgr_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN,
        SETTLE
    } state_t;

    // Bits needed to hold a count of 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sysmgr_lock_filt.sv
// Consecutive-sample filter: locked is high on the cycle the LOCK_FILT-th high sample is seen.
module sysmgr_lock_filt
    import sysmgr_pkg::*;
#(
    parameter int LOCK_FILT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic restart,
    output logic locked
);

    localparam int FW = cnt_w(LOCK_FILT);
    localparam logic [FW-1:0] LAST = FW'(LOCK_FILT - 1);

    logic [FW-1:0] cnt;

    // Saturates at LAST so a long high run can never wrap back into counting.
    always_ff @(posedge clk) begin
        if (!rst_n || restart || !pll_lock) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign locked = pll_lock && !restart && (cnt == LAST);

endmodule

// File: rtl/sysmgr_seq.sv
// Power-up / re-lock sequencer: filters PLL lock, releases domain resets in a
// staggered order, generates per-domain sync strobes and handles delay updates.
module sysmgr_seq
    import sysmgr_pkg::*;
#(
    parameter int N_DOM     = 3,
    parameter int LOCK_FILT = 64,
    parameter int STAGGER   = 16,
    parameter int DIV       = 4,
    parameter int DW        = 4,
    parameter int DLY_INIT  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pll_lock,
    input  logic [N_DOM*$clog2(DIV)-1:0] sync_phase,
    input  logic                      dly_valid,
    input  logic [DW-1:0]             dly_data,
    output logic                      dly_ready,
    output logic [DW-1:0]             delay,
    output logic [N_DOM-1:0]          dom_rst,
    output logic [N_DOM-1:0]          sync,
    output logic                      ready
);

    localparam int PW = $clog2(DIV);
    localparam int SW = cnt_w(LOCK_FILT);
    localparam int RW = cnt_w(STAGGER * (N_DOM - 1));
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_FILT - 1);
    localparam logic [RW-1:0] REL_LAST    = RW'(STAGGER * (N_DOM - 1) - 1);

    state_t            state, state_nxt;
    logic [N_DOM-1:0]  dom_rst_nxt, sync_nxt;
    logic [DW-1:0]     delay_nxt;
    logic [PW-1:0]     phase, phase_nxt;
    logic [RW-1:0]     rel_cnt, rel_nxt;
    logic [SW-1:0]     settle_cnt, settle_nxt;
    logic              restart, locked, lose;

    sysmgr_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_lock_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .restart  (restart),
        .locked   (locked)
    );

    // dly_valid/dly_ready: a request is taken on any edge where both are high;
    // dly_data is sampled only then, and lock loss always masks the handshake.
    assign dly_ready = (state == RUN) && pll_lock;
    assign ready     = (state == RUN);
    assign restart   = (state == RELEASE) || (state == RUN) || (state == SETTLE);
    assign lose      = !pll_lock && restart;

    always_comb begin
        state_nxt   = state;
        dom_rst_nxt = dom_rst;
        delay_nxt   = delay;
        phase_nxt   = '0;
        rel_nxt     = '0;
        settle_nxt  = '0;
        if (lose) begin
            state_nxt   = WAIT_LOCK;
            dom_rst_nxt = '1;
        end else begin
            case (state)
                WAIT_LOCK: if (pll_lock) state_nxt = FILTER;
                FILTER: begin
                    if (!pll_lock) begin
                        state_nxt = WAIT_LOCK;
                    end else if (locked) begin
                        dom_rst_nxt[0] = 1'b0;
                        state_nxt      = (N_DOM == 1) ? RUN : RELEASE;
                    end
                end
                RELEASE: begin
                    phase_nxt = phase + 1'b1;
                    rel_nxt   = rel_cnt + 1'b1;
                    for (int i = 1; i < N_DOM; i++) begin
                        if (rel_cnt == RW'(STAGGER * i - 1)) dom_rst_nxt[i] = 1'b0;
                    end
                    if (rel_cnt == REL_LAST) state_nxt = RUN;
                end
                RUN: begin
                    if (dly_valid) begin
                        delay_nxt   = dly_data;
                        dom_rst_nxt = '1;
                        state_nxt   = SETTLE;
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end
                SETTLE: begin
                    // Hold off for LOCK_FILT cycles, then re-qualify lock from zero.
                    if (settle_cnt == SETTLE_LAST) state_nxt = FILTER;
                    else settle_nxt = settle_cnt + 1'b1;
                end
                default: begin
                    state_nxt   = WAIT_LOCK;
                    dom_rst_nxt = '1;
                end
            endcase
        end
        for (int i = 0; i < N_DOM; i++) begin
            sync_nxt[i] = !dom_rst_nxt[i] && (phase_nxt == sync_phase[i*PW +: PW]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            dom_rst    <= '1;
            sync       <= '0;
            delay      <= DW'(DLY_INIT);
            phase      <= '0;
            rel_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            dom_rst    <= dom_rst_nxt;
            sync       <= sync_nxt;
            delay      <= delay_nxt;
            phase      <= phase_nxt;
            rel_cnt    <= rel_nxt;
            settle_cnt <= settle_nxt;
        end
    end

endmodule

// File: tb/tb_sysmgr_seq.sv
// Bench for sysmgr_seq: directed table, corner sequences and random traffic
// checked every cycle against an elapsed-time reference model.
module tb_sysmgr_seq;

    localparam int N_DOM     = 3;
    localparam int LOCK_FILT = 64;
    localparam int STAGGER   = 16;
    localparam int DIV       = 4;
    localparam int PW        = 2;
    localparam int DW        = 4;
    localparam int DLY_INIT  = 0;
    localparam int W         = 2 * N_DOM + 1 + DW;

    logic                  clk = 1'b0;
    logic                  rst_n, pll_lock, dly_valid, dly_ready, ready;
    logic [N_DOM*PW-1:0]   sync_phase;
    logic [DW-1:0]         dly_data, delay;
    logic [N_DOM-1:0]      dom_rst, sync;

    sysmgr_seq #(
        .N_DOM(N_DOM), .LOCK_FILT(LOCK_FILT), .STAGGER(STAGGER),
        .DIV(DIV), .DW(DW), .DLY_INIT(DLY_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sync_phase(sync_phase),
        .dly_valid(dly_valid), .dly_data(dly_data), .dly_ready(dly_ready),
        .delay(delay), .dom_rst(dom_rst), .sync(sync), .ready(ready)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];

    // reference model: time-based view of the sequence
    bit       m_active = 1'b0;
    int       m_t0 = 0;
    int       m_run = 0;
    int       m_settle = 0;
    logic [DW-1:0] m_delay = DW'(DLY_INIT);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input int e);
        return m_active && ((e - m_t0) >= STAGGER * (N_DOM - 1));
    endfunction

    function automatic logic [W-1:0] m_outputs();
        logic [N_DOM-1:0] d, s;
        int el;
        el = cyc - m_t0;
        for (int i = 0; i < N_DOM; i++) begin
            d[i] = !(m_active && el >= STAGGER * i);
            s[i] = m_active && el >= STAGGER * i &&
                   ((el % DIV) == int'((sync_phase >> (i * PW)) & (DIV - 1)));
        end
        return {d, s, m_ready(cyc), m_delay};
    endfunction

    task automatic m_update(input bit r, input bit l, input bit v, input logic [DW-1:0] d);
        bit was_run;
        was_run = m_ready(cyc - 1);
        if (!r) begin
            m_active = 0; m_run = 0; m_settle = 0; m_delay = DW'(DLY_INIT);
        end else if (m_active) begin
            if (!l) begin
                m_active = 0; m_run = 0;
            end else if (was_run && v) begin
                m_delay = d; m_active = 0; m_settle = LOCK_FILT; m_run = 0;
            end
        end else if (m_settle > 0) begin
            if (!l) m_settle = 0;
            else m_settle--;
        end else if (l) begin
            m_run++;
            if (m_run == LOCK_FILT) begin
                m_active = 1; m_t0 = cyc; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    // driver: one clock edge with the given inputs, scoreboarded
    task automatic step(input bit r, input bit l, input bit v, input logic [DW-1:0] d);
        logic [W-1:0] e;
        rst_n = r; pll_lock = l; dly_valid = v; dly_data = d;
        #1;
        chk("dly_ready", {31'd0, dly_ready}, {31'd0, m_ready(cyc) && l});
        @(posedge clk);
        cyc++;
        m_update(r, l, v, d);
        exp_q.push_back(m_outputs());
        #1;
        e = exp_q.pop_front();
        chk("scoreboard {dom_rst,sync,ready,delay}", 32'({dom_rst, sync, ready, delay}), 32'(e));
    endtask

    task automatic hold(input int n, input bit l);
        for (int k = 0; k < n; k++) step(1'b1, l, 1'b0, '0);
    endtask

    typedef struct {
        int            n;
        bit            lock;
        bit            valid;
        logic [DW-1:0] data;
        logic [N_DOM-1:0] exp_dom;
        bit            exp_rdy;
        logic [DW-1:0] exp_dly;
    } vec_t;

    vec_t tbl[14];
    bit   found;

    initial begin
        tbl[0]  = '{9,   1'b0, 1'b0, 4'd0, 3'b111, 1'b0, 4'd0};
        tbl[1]  = '{63,  1'b1, 1'b0, 4'd0, 3'b111, 1'b0, 4'd0};
        tbl[2]  = '{1,   1'b1, 1'b0, 4'd0, 3'b110, 1'b0, 4'd0};
        tbl[3]  = '{15,  1'b1, 1'b0, 4'd0, 3'b110, 1'b0, 4'd0};
        tbl[4]  = '{1,   1'b1, 1'b0, 4'd0, 3'b100, 1'b0, 4'd0};
        tbl[5]  = '{15,  1'b1, 1'b0, 4'd0, 3'b100, 1'b0, 4'd0};
        tbl[6]  = '{1,   1'b1, 1'b0, 4'd0, 3'b000, 1'b1, 4'd0};
        tbl[7]  = '{1,   1'b1, 1'b1, 4'd9, 3'b111, 1'b0, 4'd9};
        tbl[8]  = '{63,  1'b1, 1'b0, 4'd3, 3'b111, 1'b0, 4'd9};
        tbl[9]  = '{64,  1'b1, 1'b0, 4'd0, 3'b111, 1'b0, 4'd9};
        tbl[10] = '{1,   1'b1, 1'b0, 4'd0, 3'b110, 1'b0, 4'd9};
        tbl[11] = '{32,  1'b1, 1'b0, 4'd0, 3'b000, 1'b1, 4'd9};
        tbl[12] = '{1,   1'b0, 1'b1, 4'd5, 3'b111, 1'b0, 4'd9};
        tbl[13] = '{3,   1'b0, 1'b0, 4'd0, 3'b111, 1'b0, 4'd9};

        // reset
        rst_n = 1'b0; pll_lock = 1'b1; dly_valid = 1'b0; dly_data = '0;
        sync_phase = {2'd2, 2'd1, 2'd0};
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b1, 4'hf);
        chk("reset dom_rst", 32'(dom_rst), 32'h7);
        chk("reset sync", 32'(sync), 32'h0);
        chk("reset delay", 32'(delay), DLY_INIT);
        chk("reset ready", 32'(ready), 32'h0);

        // directed table: bring-up, delay change, re-release, lock loss with request
        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < tbl[t].n; k++) step(1'b1, tbl[t].lock, tbl[t].valid, tbl[t].data);
            chk($sformatf("tbl[%0d] dom_rst", t), 32'(dom_rst), 32'(tbl[t].exp_dom));
            chk($sformatf("tbl[%0d] ready", t), 32'(ready), 32'(tbl[t].exp_rdy));
            chk($sformatf("tbl[%0d] delay", t), 32'(delay), 32'(tbl[t].exp_dly));
        end

        // lock glitch at filter count 40 restarts the filter
        hold(40, 1'b1);
        hold(1, 1'b0);
        hold(63, 1'b1);
        chk("glitch: still held", 32'(dom_rst), 32'h7);
        hold(1, 1'b1);
        chk("glitch: delayed release", 32'(dom_rst), 32'h6);

        // synchronous reset during RELEASE
        hold(5, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("mid-release rst dom_rst", 32'(dom_rst), 32'h7);
        chk("mid-release rst delay", 32'(delay), DLY_INIT);
        chk("mid-release rst sync", 32'(sync), 32'h0);

        // sync strobe ordering in RUN with phases {2,1,0}
        hold(96, 1'b1);
        chk("run reached", 32'(ready), 32'h1);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (sync == 3'b001) found = 1'b1;
        end
        chk("sync0 seen", 32'(found), 32'h1);
        step(1'b1, 1'b1, 1'b0, '0); chk("sync phase1", 32'(sync), 32'h2);
        step(1'b1, 1'b1, 1'b0, '0); chk("sync phase2", 32'(sync), 32'h4);
        step(1'b1, 1'b1, 1'b0, '0); chk("sync phase3", 32'(sync), 32'h0);
        step(1'b1, 1'b1, 1'b0, '0); chk("sync period", 32'(sync), 32'h1);

        // random traffic against the model
        for (int k = 0; k < 6000; k++) begin
            if (k % 500 == 0) sync_phase = N_DOM*PW'($urandom);
            step($urandom_range(0, 1999) != 0, $urandom_range(0, 299) != 0,
                 $urandom_range(0, 29) == 0, DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
